// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control path.
package rv_ctrl_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned WAIT_W   = 8;
   localparam int unsigned CNT_W    = 32;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_IMM   = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_AUIPC = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;

   localparam logic ADDR_PC   = 1'b0;
   localparam logic ADDR_ALU  = 1'b1;
   localparam logic WB_ALU    = 1'b0;
   localparam logic WB_MEM    = 1'b1;
   localparam logic ALU_A_RS1 = 1'b0;
   localparam logic ALU_A_PC  = 1'b1;
   localparam logic ALU_B_RS2 = 1'b0;
   localparam logic ALU_B_IMM = 1'b1;

endpackage

// File: rtl/opcode_class.sv
// Combinational classification of the 7-bit RISC-V major opcode.
module opcode_class
   import rv_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output logic                is_load,
   output logic                is_store,
   output logic                is_alu_imm,
   output logic                is_auipc,
   output logic                is_rtype,
   output logic                is_legal
);

   assign is_load    = (opcode == OP_LOAD);
   assign is_store   = (opcode == OP_STORE);
   assign is_alu_imm = (opcode == OP_IMM);
   assign is_auipc   = (opcode == OP_AUIPC);
   assign is_rtype   = (opcode == OP_RTYPE);
   assign is_legal   = is_load | is_store | is_alu_imm | is_auipc | is_rtype;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer over one shared memory port.
// Optional performance counters are enabled with MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                addr_sel,
   output logic                ir_we,
   output logic                pc_we,
   output logic                reg_we,
   output logic                alu_a_sel,
   output logic                alu_b_sel,
   output logic                wb_sel,
   output logic                illegal,
   output logic                mem_timeout
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    instret_cnt
`endif
);

   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_inc;
   logic              is_load, is_store, is_alu_imm, is_auipc, is_rtype, is_legal;
   logic              mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c, reg_we_c;
   logic              alu_a_sel_c, alu_b_sel_c, wb_sel_c;
   logic              illegal_set, timeout_set;

   opcode_class u_opcode_class (
      .opcode     (opcode),
      .is_load    (is_load),
      .is_store   (is_store),
      .is_alu_imm (is_alu_imm),
      .is_auipc   (is_auipc),
      .is_rtype   (is_rtype),
      .is_legal   (is_legal)
   );

   assign wait_inc = wait_cnt + WAIT_W'(1);

   // Timeout fires when this wait cycle would bring the counter to the cap.
   always_comb begin
      state_nxt   = state;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      addr_sel_c  = ADDR_PC;
      ir_we_c     = 1'b0;
      pc_we_c     = 1'b0;
      reg_we_c    = 1'b0;
      alu_a_sel_c = ALU_A_RS1;
      alu_b_sel_c = ALU_B_RS2;
      wb_sel_c    = WB_ALU;
      illegal_set = 1'b0;
      timeout_set = 1'b0;
      case (state)
         FETCH: begin
            mem_req_c  = 1'b1;
            addr_sel_c = ADDR_PC;
            if (mem_ready) begin
               ir_we_c   = 1'b1;
               pc_we_c   = 1'b1;
               state_nxt = DECODE;
            end else if (wait_inc == WAIT_MAX) begin
               timeout_set = 1'b1;
               state_nxt   = HALT;
            end
         end
         DECODE: begin
            if (is_legal) begin
               state_nxt = EXEC;
            end else begin
               illegal_set = 1'b1;
               state_nxt   = HALT;
            end
         end
         EXEC: begin
            alu_a_sel_c = is_auipc ? ALU_A_PC : ALU_A_RS1;
            alu_b_sel_c = is_rtype ? ALU_B_RS2 : ALU_B_IMM;
            if (is_load || is_store) begin
               state_nxt = MEM;
            end else if (is_alu_imm || is_auipc || is_rtype) begin
               state_nxt = WB;
            end else begin
               illegal_set = 1'b1;
               state_nxt   = HALT;
            end
         end
         MEM: begin
            mem_req_c  = 1'b1;
            addr_sel_c = ADDR_ALU;
            mem_we_c   = is_store;
            if (mem_ready) begin
               state_nxt = is_store ? FETCH : WB;
            end else if (wait_inc == WAIT_MAX) begin
               timeout_set = 1'b1;
               state_nxt   = HALT;
            end
         end
         WB: begin
            reg_we_c  = 1'b1;
            wb_sel_c  = is_load ? WB_MEM : WB_ALU;
            state_nxt = FETCH;
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = HALT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         wait_cnt    <= '0;
         illegal     <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (illegal_set) illegal <= 1'b1;
         if (timeout_set) mem_timeout <= 1'b1;
         if ((state_nxt != state) && ((state_nxt == FETCH) || (state_nxt == MEM)))
            wait_cnt <= '0;
         else if (mem_req_c && !mem_ready)
            wait_cnt <= wait_inc;
      end
   end

   // Reset masks every strobe immediately so no access or writeback leaks out.
   assign mem_req   = mem_req_c   & ~reset;
   assign mem_we    = mem_we_c    & ~reset;
   assign addr_sel  = addr_sel_c  & ~reset;
   assign ir_we     = ir_we_c     & ~reset;
   assign pc_we     = pc_we_c     & ~reset;
   assign reg_we    = reg_we_c    & ~reset;
   assign alu_a_sel = alu_a_sel_c & ~reset;
   assign alu_b_sel = alu_b_sel_c & ~reset;
   assign wb_sel    = wb_sel_c    & ~reset;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic instret_c;

   assign instret_c = (state == WB) || ((state == MEM) && is_store && mem_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state != HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (instret_c) instret_cnt <= instret_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl (MEM_WAIT_MAX = 4).
module tb_multicycle_ctrl;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_BAD   = 7'b1111111;

   // {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, alu_a, alu_b, wb_sel, illegal, timeout}
   localparam logic [10:0] E_IDLE    = 11'b0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [10:0] E_F_DONE  = 11'b1_0_0_1_1_0_0_0_0_0_0;
   localparam logic [10:0] E_F_WAIT  = 11'b1_0_0_0_0_0_0_0_0_0_0;
   localparam logic [10:0] E_EX_IMM  = 11'b0_0_0_0_0_0_0_1_0_0_0;
   localparam logic [10:0] E_EX_AUI  = 11'b0_0_0_0_0_0_1_1_0_0_0;
   localparam logic [10:0] E_WB_ALU  = 11'b0_0_0_0_0_1_0_0_0_0_0;
   localparam logic [10:0] E_WB_LD   = 11'b0_0_0_0_0_1_0_0_1_0_0;
   localparam logic [10:0] E_MEM_LD  = 11'b1_0_1_0_0_0_0_0_0_0_0;
   localparam logic [10:0] E_MEM_ST  = 11'b1_1_1_0_0_0_0_0_0_0_0;
   localparam logic [10:0] E_HLT_ILL = 11'b0_0_0_0_0_0_0_0_0_1_0;
   localparam logic [10:0] E_HLT_TO  = 11'b0_0_0_0_0_0_0_0_0_0_1;

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic        rdy;
      logic [10:0] exp;
      string       name;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we;
   logic       alu_a_sel, alu_b_sel, wb_sel, illegal, mem_timeout;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .addr_sel    (addr_sel),
      .ir_we       (ir_we),
      .pc_we       (pc_we),
      .reg_we      (reg_we),
      .alu_a_sel   (alu_a_sel),
      .alu_b_sel   (alu_b_sel),
      .wb_sel      (wb_sel),
      .illegal     (illegal),
      .mem_timeout (mem_timeout)
`ifdef MULTICYCLE_CTRL_PERF_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
`endif
   );

   function automatic logic [10:0] outs();
      return {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we,
              alu_a_sel, alu_b_sel, wb_sel, illegal, mem_timeout};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   // Drive inputs on the falling edge, sample combinational outputs 1 ns later.
   task automatic step(input logic rst, input logic [6:0] op, input logic rdy,
                       input logic [10:0] exp, input string name);
      @(negedge clk);
      reset     = rst;
      opcode    = op;
      mem_ready = rdy;
      #1;
      chk(name, 32'(outs()), 32'(exp));
   endtask

   task automatic add(input logic rst, input logic [6:0] op, input logic rdy,
                      input logic [10:0] exp, input string name);
      vec_t v;
      v.rst = rst; v.op = op; v.rdy = rdy; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      add(1'b1, '0, 1'b0, E_IDLE, "reset");
      // addi, zero wait: 4 cycles
      add(1'b0, OPC_IMM, 1'b1, E_F_DONE, "addi fetch");
      add(1'b0, OPC_IMM, 1'b1, E_IDLE,   "addi decode");
      add(1'b0, OPC_IMM, 1'b1, E_EX_IMM, "addi exec");
      add(1'b0, OPC_IMM, 1'b1, E_WB_ALU, "addi wb");
      // R-type selects rs1/rs2
      add(1'b0, OPC_RTYPE, 1'b1, E_F_DONE, "rtype fetch");
      add(1'b0, OPC_RTYPE, 1'b1, E_IDLE,   "rtype decode");
      add(1'b0, OPC_RTYPE, 1'b1, E_IDLE,   "rtype exec");
      add(1'b0, OPC_RTYPE, 1'b1, E_WB_ALU, "rtype wb");
      // AUIPC selects old PC and immediate
      add(1'b0, OPC_AUIPC, 1'b1, E_F_DONE, "auipc fetch");
      add(1'b0, OPC_AUIPC, 1'b1, E_IDLE,   "auipc decode");
      add(1'b0, OPC_AUIPC, 1'b1, E_EX_AUI, "auipc exec");
      add(1'b0, OPC_AUIPC, 1'b1, E_WB_ALU, "auipc wb");
      // load with 3 wait cycles in MEM: 8 cycles
      add(1'b0, OPC_LOAD, 1'b1, E_F_DONE, "load fetch");
      add(1'b0, OPC_LOAD, 1'b1, E_IDLE,   "load decode");
      add(1'b0, OPC_LOAD, 1'b1, E_EX_IMM, "load exec");
      for (int i = 0; i < 3; i++) add(1'b0, OPC_LOAD, 1'b0, E_MEM_LD, "load mem wait");
      add(1'b0, OPC_LOAD, 1'b1, E_MEM_LD, "load mem done");
      add(1'b0, OPC_LOAD, 1'b1, E_WB_LD,  "load wb");
      // store with 3 waits in FETCH and 3 in MEM; counter must clear on MEM entry
      for (int i = 0; i < 3; i++) add(1'b0, OPC_STORE, 1'b0, E_F_WAIT, "store fetch wait");
      add(1'b0, OPC_STORE, 1'b1, E_F_DONE, "store fetch");
      add(1'b0, OPC_STORE, 1'b1, E_IDLE,   "store decode");
      add(1'b0, OPC_STORE, 1'b1, E_EX_IMM, "store exec");
      for (int i = 0; i < 3; i++) add(1'b0, OPC_STORE, 1'b0, E_MEM_ST, "store mem wait");
      add(1'b0, OPC_STORE, 1'b1, E_MEM_ST, "store mem done");
      // store returns straight to FETCH
      add(1'b0, OPC_IMM, 1'b1, E_F_DONE, "post-store fetch");
      add(1'b0, OPC_IMM, 1'b1, E_IDLE,   "post-store decode");
      add(1'b0, OPC_IMM, 1'b1, E_EX_IMM, "post-store exec");
      add(1'b0, OPC_IMM, 1'b1, E_WB_ALU, "post-store wb");
      // unsupported opcode halts after decode
      add(1'b0, OPC_BAD, 1'b1, E_F_DONE,  "illegal fetch");
      add(1'b0, OPC_BAD, 1'b1, E_IDLE,    "illegal decode");
      add(1'b0, OPC_BAD, 1'b1, E_HLT_ILL, "illegal halt");

      foreach (vecs[i]) step(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].exp, vecs[i].name);

      // HALT is terminal even with a legal opcode and mem_ready high
      for (int i = 0; i < 20; i++) step(1'b0, OPC_IMM, 1'b1, E_HLT_ILL, "halt hold");
      step(1'b1, OPC_IMM, 1'b1, E_IDLE, "reset clears illegal");

      // four fetch waits reach the cap of 4
      for (int i = 0; i < 4; i++) step(1'b0, OPC_IMM, 1'b0, E_F_WAIT, "timeout wait");
      step(1'b0, OPC_IMM, 1'b1, E_HLT_TO, "timeout halt");

      // ready on the cycle the counter would hit the cap: completion wins
      step(1'b1, OPC_IMM, 1'b0, E_IDLE, "reset before race");
      for (int i = 0; i < 3; i++) step(1'b0, OPC_IMM, 1'b0, E_F_WAIT, "race wait");
      step(1'b0, OPC_IMM, 1'b1, E_F_DONE, "race complete");
      step(1'b0, OPC_IMM, 1'b1, E_IDLE,   "race decode");
      step(1'b0, OPC_IMM, 1'b1, E_EX_IMM, "race exec");
      step(1'b0, OPC_IMM, 1'b1, E_WB_ALU, "race wb");

      // asynchronous reset mid-FETCH drops mem_req at once
      step(1'b0, OPC_IMM, 1'b0, E_F_WAIT, "pre-reset fetch");
      #2 reset = 1'b1;
      #1 chk("async reset fetch", 32'(outs()), 32'(E_IDLE));

      // asynchronous reset mid-WB kills reg_we at once
      step(1'b0, OPC_IMM, 1'b1, E_F_DONE, "abort fetch");
      step(1'b0, OPC_IMM, 1'b1, E_IDLE,   "abort decode");
      step(1'b0, OPC_IMM, 1'b1, E_EX_IMM, "abort exec");
      step(1'b0, OPC_IMM, 1'b1, E_WB_ALU, "abort wb");
      #1 reset = 1'b1;
      #1 chk("async reset wb", 32'(outs()), 32'(E_IDLE));

`ifdef MULTICYCLE_CTRL_PERF_EN
      chk("cycle_cnt reset", cycle_cnt, 32'd0);
      step(1'b0, OPC_AUIPC, 1'b1, E_F_DONE, "perf fetch");
      step(1'b0, OPC_AUIPC, 1'b1, E_IDLE,   "perf decode");
      step(1'b0, OPC_AUIPC, 1'b1, E_EX_AUI, "perf exec");
      chk("instret before wb", instret_cnt, 32'd0);
      step(1'b0, OPC_AUIPC, 1'b1, E_WB_ALU, "perf wb");
      @(negedge clk);
      #1;
      chk("instret after auipc", instret_cnt, 32'd1);
      chk("cycle_cnt after auipc", cycle_cnt, 32'd4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RISC-V core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback over a single shared instruction/data memory port. It drives the datapath enables and mux selects around the register file, ALU, immediate generator and PC/IR registers, and halts on unsupported opcodes.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 255: cap on the memory wait counter before `mem_timeout` asserts (8-bit counter).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  `InstCode[6:0]` from the IR; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request; held until `mem_ready`.
- `mem_we`  out  1  store access; valid only with `mem_req`.
- `addr_sel`  out  1  0 = PC, 1 = ALU result register.
- `ir_we`  out  1  load IR and old-PC register from memory read data.
- `pc_we`  out  1  PC <= PC+4.
- `reg_we`  out  1  register-file write.
- `alu_a_sel`  out  1  0 = rs1, 1 = old PC.
- `alu_b_sel`  out  1  0 = rs2, 1 = ImmGen output.
- `wb_sel`  out  1  0 = ALU result register, 1 = memory data register.
- `illegal`  out  1  sticky; unsupported opcode seen.
- `mem_timeout`  out  1  sticky; wait exceeded `MEM_WAIT_MAX`.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. 3-bit encoding. Reset state is FETCH.
- FETCH:
  - `mem_req=1`, `addr_sel=0`, `mem_we=0`.
  - On `mem_ready`: `ir_we=1` and `pc_we=1` (same cycle), then go to DECODE.
- DECODE:
  - Supported opcodes: 0000011 load, 0010011 I-ALU, 0100011 store, 0010111 AUIPC, 0110011 R-type. Any of these goes to EXEC.
  - Any other opcode goes to HALT and sets `illegal`.
- EXEC: ALU result register loads every cycle in this state. Selects per opcode:
  - load, store, I-ALU: `alu_a_sel=0`, `alu_b_sel=1`.
  - R-type: `alu_a_sel=0`, `alu_b_sel=0`.
  - AUIPC: `alu_a_sel=1`, `alu_b_sel=1`.
  - Next state: load/store go to MEM; all others go to WB.
- MEM:
  - `mem_req=1`, `addr_sel=1`, `mem_we=1` for store and 0 for load.
  - On `mem_ready`: load goes to WB; store goes to FETCH.
- WB:
  - `reg_we=1` for exactly one cycle.
  - `wb_sel=1` for load, 0 otherwise.
  - Next state is FETCH.
- HALT:
  - Terminal state; all enables 0.
  - Only `reset` exits it.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle `mem_req && !mem_ready`.
  - Reaching `MEM_WAIT_MAX` sets `mem_timeout` and moves to HALT.
  - `mem_req` drops in the same transition.

## Timing
- All outputs are 0 during and after reset; `illegal` and `mem_timeout` reset to 0.
- Asynchronous reset mid-access drops `mem_req` immediately. No partial writeback is allowed: `reg_we` and `pc_we` are forced to 0 asynchronously.
- Enables `ir_we`, `pc_we`, `reg_we` are combinational from state and `mem_ready`. None of them is ever high for more than one cycle per instruction.
- Latency with zero wait (`mem_ready` high on the first request cycle):
  - I-ALU, R-type, AUIPC: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - Each memory wait cycle adds 1.
- `mem_ready` is ignored when `mem_req=0`.
- `mem_ready` arriving in the same cycle the counter hits `MEM_WAIT_MAX`: completion wins and no timeout is flagged.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN`:
  - When defined, adds outputs `cycle_cnt[31:0]` and `instret_cnt[31:0]`, both reset to 0.
  - `cycle_cnt` increments every non-HALT cycle.
  - `instret_cnt` increments on the final cycle of each instruction (WB, or store MEM with `mem_ready`).
  - Both wrap from 0xFFFFFFFF to 0.
  - When undefined, the ports and logic are absent.

## Structure
- Shared package `rv_ctrl_pkg`:
  - State enum.
  - Opcode localparams: OP_LOAD, OP_IMM, OP_STORE, OP_AUIPC, OP_RTYPE.
  - Select encodings: ADDR_PC/ADDR_ALU, WB_ALU/WB_MEM.
- Optional sub-module `opcode_class`: combinational decode of the 7-bit opcode into is_load/is_store/is_alu_imm/is_auipc/is_rtype/is_legal.

## Test plan
- Reset, then addi (opcode 0010011), `mem_ready` always 1 → states FETCH, DECODE, EXEC, WB; `alu_b_sel=1` in EXEC; `reg_we` high only in cycle 4.
- Load 0000011 with `mem_ready` delayed 3 cycles in MEM → 8 cycles total; `wb_sel=1` with `reg_we`; `mem_we=0` throughout.
- Store 0100011 → `mem_we=1` with `addr_sel=1` in MEM; `reg_we` never asserts; returns to FETCH after `mem_ready`.
- AUIPC 0010111 → `alu_a_sel=1`, `alu_b_sel=1` in EXEC; `instret_cnt` goes 0→1 when PERF_EN is defined.
- Opcode 1111111 → HALT after DECODE; `illegal=1`; no `mem_req` for 20 cycles; `reset` clears it.
- Hold `mem_ready=0` with `MEM_WAIT_MAX=4` → `mem_timeout=1` after 4 wait cycles; `reset` asserted mid-FETCH drops `mem_req` in the same cycle.
